// File: rtl/rx_pkt_assembler.sv
// rx_pkt_assembler
// TCP RX front end: filters notifications by length, requests the payload
// from the stack, and streams it out with the notification metadata attached.
// The byte enables and TLAST on the output come from the notified length.
// Length mismatches between the stack and the notification are recovered
// from and counted.
`timescale 1ns/1ps

module rx_pkt_assembler #(
    parameter int DATA_W     = 512,
    parameter int META_W     = 88,
    parameter int MAX_LEN    = 1536,
    parameter int ALIGN_ONLY = 0,
    parameter int CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [META_W-1:0]        s_axis_notifications_TDATA,
    input  logic                     s_axis_notifications_TVALID,
    output logic                     s_axis_notifications_TREADY,

    output logic [31:0]              m_axis_read_package_TDATA,
    output logic                     m_axis_read_package_TVALID,
    input  logic                     m_axis_read_package_TREADY,

    input  logic [DATA_W-1:0]        s_axis_rx_data_TDATA,
    input  logic                     s_axis_rx_data_TLAST,
    input  logic                     s_axis_rx_data_TVALID,
    output logic                     s_axis_rx_data_TREADY,

    output logic [META_W+DATA_W-1:0] m_axis_pkt_TDATA,
    output logic [DATA_W/8-1:0]      m_axis_pkt_TKEEP,
    output logic                     m_axis_pkt_TLAST,
    output logic                     m_axis_pkt_TVALID,
    input  logic                     m_axis_pkt_TREADY,

    output logic [CNT_W-1:0]         stat_drop_cnt,
    output logic [CNT_W-1:0]         stat_err_cnt,
    output logic                     busy
);

    localparam int BYTES = DATA_W / 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_FLUSH  = 2'd3;

    logic [1:0]               state;
    logic [1:0]               state_next;

    // Context of the packet currently being assembled
    logic [META_W-1:0]        meta_q;
    logic [15:0]              beats_left;
    logic [BYTES-1:0]         keep_last;

    // Registered output stage
    logic                     m_valid;
    logic [META_W+DATA_W-1:0] m_data;
    logic [BYTES-1:0]         m_keep;
    logic                     m_last;

    logic [CNT_W-1:0]         drop_cnt;
    logic [CNT_W-1:0]         err_cnt;

    // Notification length decode
    logic [15:0]              notif_len;
    logic [15:0]              len_rem;
    logic [15:0]              beats_calc;
    logic [BYTES-1:0]         keep_calc;
    logic                     len_drop;

    // Handshakes and per-cycle events
    logic                     notif_fire;
    logic                     rx_ready;
    logic                     rx_fire;
    logic                     pkt_fire;
    logic                     counted_last;
    logic                     load;
    logic                     drop_inc;
    logic                     err_inc;

    assign notif_len  = s_axis_notifications_TDATA[31:16];
    assign len_rem    = notif_len % 16'(BYTES);
    assign beats_calc = 16'((17'(notif_len) + 17'(BYTES - 1)) / 17'(BYTES));

    // Zero, oversized and (in legacy mode) unaligned lengths are dropped.
    assign len_drop = (notif_len == 16'd0)
                   || (32'(notif_len) > 32'(MAX_LEN))
                   || ((ALIGN_ONLY != 0) && (len_rem != 16'd0));

    // Byte enables for the final beat: the low len%BYTES bytes, or all of them
    // when the length is a whole number of beats.
    always_comb begin
        // NOTE: give every combinational output a default before any branch or
        // loop so no path leaves it unassigned; otherwise a latch is inferred.
        keep_calc = '0;
        for (int i = 0; i < BYTES; i++) begin
            keep_calc[i] = (len_rem == 16'd0) || (i < int'(len_rem));
        end
    end

    // Notifications are only taken in IDLE, and never while reset is held.
    assign s_axis_notifications_TREADY = (state == S_IDLE) && !rst;
    assign notif_fire = s_axis_notifications_TVALID && s_axis_notifications_TREADY;

    // In STREAM a beat is taken only when the output register can accept it;
    // in FLUSH everything is swallowed until the stack's TLAST.
    assign rx_ready = ((state == S_STREAM) && (!m_valid || m_axis_pkt_TREADY))
                   || (state == S_FLUSH);
    assign s_axis_rx_data_TREADY = rx_ready;
    assign rx_fire  = s_axis_rx_data_TVALID && rx_ready;
    assign pkt_fire = m_valid && m_axis_pkt_TREADY;

    assign counted_last = (beats_left == 16'd1);
    assign load         = (state == S_STREAM) && rx_fire;
    assign drop_inc     = notif_fire && len_drop;
    // A mismatch is any beat where the stack's TLAST disagrees with our count.
    assign err_inc      = load && (counted_last != s_axis_rx_data_TLAST);

    // Next-state decode for the packet FSM
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (notif_fire && !len_drop) state_next = S_REQ;
            end
            S_REQ: begin
                if (m_axis_read_package_TREADY) state_next = S_STREAM;
            end
            S_STREAM: begin
                if (rx_fire) begin
                    if (counted_last && !s_axis_rx_data_TLAST) begin
                        state_next = S_FLUSH;
                    end else if (counted_last || s_axis_rx_data_TLAST) begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (rx_fire && s_axis_rx_data_TLAST) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of block evaluation order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch metadata and beat accounting for an accepted notification
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q     <= '0;
            beats_left <= '0;
            keep_last  <= '0;
        end else if (notif_fire && !len_drop) begin
            meta_q     <= s_axis_notifications_TDATA;
            beats_left <= beats_calc;
            keep_last  <= keep_calc;
        end else if (load) begin
            beats_left <= beats_left - 16'd1;
        end
    end

    // Output register: loads one beat per accepted rx beat, holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= {meta_q, s_axis_rx_data_TDATA};
            // A truncated packet ends on a full beat; only the counted last
            // beat carries the length-derived partial enables.
            m_keep  <= counted_last ? keep_last : '1;
            m_last  <= counted_last || s_axis_rx_data_TLAST;
        end else if (pkt_fire) begin
            m_valid <= 1'b0;
        end
    end

    // Saturating statistics counters; drop and error may bump in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
            if (err_inc && (err_cnt != '1))   err_cnt  <= err_cnt + 1'b1;
        end
    end

    assign m_axis_read_package_TVALID = (state == S_REQ);
    assign m_axis_read_package_TDATA  = {meta_q[31:16], meta_q[15:0]};

    assign m_axis_pkt_TVALID = m_valid;
    assign m_axis_pkt_TDATA  = m_data;
    assign m_axis_pkt_TKEEP  = m_keep;
    assign m_axis_pkt_TLAST  = m_last;

    assign stat_drop_cnt = drop_cnt;
    assign stat_err_cnt  = err_cnt;
    assign busy          = (state != S_IDLE) || m_valid;

endmodule

// File: tb/tb_rx_pkt_assembler.sv
// Directed testbench for rx_pkt_assembler (DATA_W=512, 64-byte beats).
// A second instance with ALIGN_ONLY=1 covers the legacy alignment filter.
`timescale 1ns/1ps

module tb_rx_pkt_assembler;

    localparam int DATA_W = 512;
    localparam int META_W = 88;
    localparam int BYTES  = 64;
    localparam int CNT_W  = 32;
    localparam int PW     = META_W + DATA_W;
    localparam logic [55:0] OPQ = 56'hC0FF_EE12_3456_78;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [META_W-1:0] n_data = '0;
    logic              n_valid = 1'b0;
    logic              n_ready;
    logic [31:0]       rp_data;
    logic              rp_valid;
    logic              rp_ready = 1'b1;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_last = 1'b0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [PW-1:0]     pkt_data;
    logic [BYTES-1:0]  pkt_keep;
    logic              pkt_last;
    logic              pkt_valid;
    logic              pkt_ready = 1'b1;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              busy;

    // Legacy-mode instance
    logic [META_W-1:0] a_n_data = '0;
    logic              a_n_valid = 1'b0;
    logic              a_n_ready;
    logic [31:0]       a_rp_data;
    logic              a_rp_valid;
    logic              a_rx_ready;
    logic [PW-1:0]     a_pkt_data;
    logic [BYTES-1:0]  a_pkt_keep;
    logic              a_pkt_last;
    logic              a_pkt_valid;
    logic [CNT_W-1:0]  a_drop;
    logic [CNT_W-1:0]  a_err;
    logic              a_busy;

    rx_pkt_assembler #(.DATA_W(DATA_W), .META_W(META_W), .MAX_LEN(1536), .ALIGN_ONLY(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .s_axis_notifications_TDATA(n_data), .s_axis_notifications_TVALID(n_valid),
        .s_axis_notifications_TREADY(n_ready),
        .m_axis_read_package_TDATA(rp_data), .m_axis_read_package_TVALID(rp_valid),
        .m_axis_read_package_TREADY(rp_ready),
        .s_axis_rx_data_TDATA(rx_data), .s_axis_rx_data_TLAST(rx_last),
        .s_axis_rx_data_TVALID(rx_valid), .s_axis_rx_data_TREADY(rx_ready),
        .m_axis_pkt_TDATA(pkt_data), .m_axis_pkt_TKEEP(pkt_keep), .m_axis_pkt_TLAST(pkt_last),
        .m_axis_pkt_TVALID(pkt_valid), .m_axis_pkt_TREADY(pkt_ready),
        .stat_drop_cnt(drop_cnt), .stat_err_cnt(err_cnt), .busy(busy)
    );

    rx_pkt_assembler #(.DATA_W(DATA_W), .META_W(META_W), .MAX_LEN(1536), .ALIGN_ONLY(1), .CNT_W(CNT_W)) dut_align (
        .clk(clk), .rst(rst),
        .s_axis_notifications_TDATA(a_n_data), .s_axis_notifications_TVALID(a_n_valid),
        .s_axis_notifications_TREADY(a_n_ready),
        .m_axis_read_package_TDATA(a_rp_data), .m_axis_read_package_TVALID(a_rp_valid),
        .m_axis_read_package_TREADY(1'b1),
        .s_axis_rx_data_TDATA('0), .s_axis_rx_data_TLAST(1'b0),
        .s_axis_rx_data_TVALID(1'b0), .s_axis_rx_data_TREADY(a_rx_ready),
        .m_axis_pkt_TDATA(a_pkt_data), .m_axis_pkt_TKEEP(a_pkt_keep), .m_axis_pkt_TLAST(a_pkt_last),
        .m_axis_pkt_TVALID(a_pkt_valid), .m_axis_pkt_TREADY(1'b1),
        .stat_drop_cnt(a_drop), .stat_err_cnt(a_err), .busy(a_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Monitor state, sampled on the falling edge
    int               cyc = 0;
    int               acc_cyc = 0;
    int               rp_cyc = 0;
    int               stall_err = 0;
    int               a_rp_cnt = 0;
    bit               prev_stall = 1'b0;
    logic [PW-1:0]    prev_data = '0;
    logic [BYTES-1:0] prev_keep = '0;
    logic             prev_last = 1'b0;
    logic [31:0]      rp_q[$];
    logic [PW-1:0]    pd_q[$];
    logic [BYTES-1:0] pk_q[$];
    logic             pl_q[$];
    bit               rand_on = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (n_valid && n_ready) acc_cyc <= cyc;
            if (rp_valid && rp_ready) begin
                rp_q.push_back(rp_data);
                rp_cyc <= cyc;
            end
            if (pkt_valid && pkt_ready) begin
                pd_q.push_back(pkt_data);
                pk_q.push_back(pkt_keep);
                pl_q.push_back(pkt_last);
            end
            if (prev_stall && !(pkt_valid && pkt_data == prev_data && pkt_keep == prev_keep
                                && pkt_last == prev_last))
                stall_err <= stall_err + 1;
            prev_stall <= pkt_valid && !pkt_ready;
            prev_data  <= pkt_data;
            prev_keep  <= pkt_keep;
            prev_last  <= pkt_last;
            if (a_rp_valid) a_rp_cnt <= a_rp_cnt + 1;
        end
    end

    // Random back-pressure on the packet output while enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_on) pkt_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "simulation time limit");
    end

    function automatic logic [DATA_W-1:0] mk_beat(input logic [15:0] seed);
        logic [DATA_W-1:0] b;
        b = '0;
        for (int k = 0; k < DATA_W / 32; k++) b[k*32 +: 32] = {seed, 16'(k)};
        return b;
    endfunction

    function automatic logic [META_W-1:0] mk_meta(input logic [15:0] len, input logic [15:0] sess);
        return {OPQ, len, sess};
    endfunction

    function automatic void clear_q();
        rp_q.delete();
        pd_q.delete();
        pk_q.delete();
        pl_q.delete();
    endfunction

    // All drive tasks start and finish just after a rising edge.
    task automatic send_notif(input logic [15:0] len, input logic [15:0] sess);
        bit done = 1'b0;
        n_data  = mk_meta(len, sess);
        n_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (n_ready) done = 1'b1;
        end
        @(posedge clk);
        #1;
        n_valid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL notif_accept len=%0d got ready=0 required ready=1", len);
        end
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
        bit done = 1'b0;
        rx_data  = d;
        rx_last  = last;
        rx_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (rx_ready) done = 1'b1;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL rx_accept got ready=0 required ready=1");
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_idle got busy=1 required busy=0", tag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL rst_pkt_valid got=%b exp=0", pkt_valid); end
        checks++; if (rp_valid !== 1'b0) begin failures++; $display("FAIL rst_rp_valid got=%b exp=0", rp_valid); end
        checks++; if (n_ready !== 1'b0) begin failures++; $display("FAIL rst_notif_ready got=%b exp=0", n_ready); end
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL rst_rx_ready got=%b exp=0", rx_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (drop_cnt !== 32'd0 || err_cnt !== 32'd0) begin
            failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", drop_cnt, err_cnt); end
        checks++; if (pkt_data !== '0) begin failures++; $display("FAIL rst_pkt_data got=%h exp=0", pkt_data); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (n_ready !== 1'b1) begin failures++; $display("FAIL idle_notif_ready got=%b exp=1", n_ready); end
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] b0, b1;
        b0 = mk_beat(16'h0100);
        b1 = mk_beat(16'h0101);
        clear_q();
        send_notif(16'd128, 16'h0011);
        send_beat(b0, 1'b0);
        send_beat(b1, 1'b1);
        wait_idle("basic");
        checks++; if (rp_q.size() !== 1) begin failures++; $display("FAIL basic_req_count got=%0d exp=1", rp_q.size()); end
        else begin
            checks++; if (rp_q[0] !== {16'd128, 16'h0011}) begin
                failures++; $display("FAIL basic_req_data got=%h exp=%h", rp_q[0], {16'd128, 16'h0011}); end
        end
        checks++; if (rp_cyc - acc_cyc !== 1) begin
            failures++; $display("FAIL basic_req_latency got=%0d exp=1", rp_cyc - acc_cyc); end
        checks++; if (pd_q.size() !== 2) begin failures++; $display("FAIL basic_beat_count got=%0d exp=2", pd_q.size()); end
        else begin
            checks++; if (pd_q[0] !== {mk_meta(16'd128, 16'h0011), b0}) begin
                failures++; $display("FAIL basic_beat0_data got=%h", pd_q[0]); end
            checks++; if (pd_q[1] !== {mk_meta(16'd128, 16'h0011), b1}) begin
                failures++; $display("FAIL basic_beat1_data got=%h", pd_q[1]); end
            checks++; if (pk_q[0] !== {BYTES{1'b1}} || pk_q[1] !== {BYTES{1'b1}}) begin
                failures++; $display("FAIL basic_keep got=%h/%h exp=all-ones", pk_q[0], pk_q[1]); end
            checks++; if (pl_q[0] !== 1'b0 || pl_q[1] !== 1'b1) begin
                failures++; $display("FAIL basic_last got=%b%b exp=01", pl_q[0], pl_q[1]); end
        end
    endtask

    task automatic test_partial_keep();
        bit ar;
        clear_q();
        send_notif(16'd100, 16'h0022);
        send_beat(mk_beat(16'h0200), 1'b0);
        send_beat(mk_beat(16'h0201), 1'b1);
        wait_idle("partial");
        checks++; if (pk_q.size() !== 2) begin failures++; $display("FAIL partial_beat_count got=%0d exp=2", pk_q.size()); end
        else begin
            checks++; if (pk_q[0] !== {BYTES{1'b1}}) begin
                failures++; $display("FAIL partial_keep0 got=%h exp=all-ones", pk_q[0]); end
            checks++; if (pk_q[1] !== 64'h0000_000F_FFFF_FFFF) begin
                failures++; $display("FAIL partial_keep1 got=%h exp=0000000fffffffff", pk_q[1]); end
            checks++; if (pl_q[1] !== 1'b1) begin failures++; $display("FAIL partial_last got=%b exp=1", pl_q[1]); end
        end
        checks++; if (drop_cnt !== 32'd0) begin failures++; $display("FAIL partial_drop got=%0d exp=0", drop_cnt); end
        // Legacy instance: unaligned length is dropped, aligned one is requested
        a_n_data  = mk_meta(16'd100, 16'h0022);
        a_n_valid = 1'b1;
        @(negedge clk);
        ar = a_n_ready;
        @(posedge clk);
        #1;
        a_n_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ar !== 1'b1) begin failures++; $display("FAIL align_ready got=%b exp=1", ar); end
        checks++; if (a_drop !== 32'd1) begin failures++; $display("FAIL align_drop got=%0d exp=1", a_drop); end
        checks++; if (a_rp_cnt !== 0) begin failures++; $display("FAIL align_no_req got=%0d exp=0", a_rp_cnt); end
        @(posedge clk);
        #1;
        a_n_data  = mk_meta(16'd128, 16'h0023);
        a_n_valid = 1'b1;
        @(posedge clk);
        #1;
        a_n_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (a_rp_cnt !== 1 || a_drop !== 32'd1) begin
            failures++; $display("FAIL align_accept got req=%0d drop=%0d exp req=1 drop=1", a_rp_cnt, a_drop); end
        checks++; if (a_rp_data !== {16'd128, 16'h0023}) begin
            failures++; $display("FAIL align_req_data got=%h exp=%h", a_rp_data, {16'd128, 16'h0023}); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_drop_b2b();
        bit r0, r1, rv_seen;
        clear_q();
        rv_seen = 1'b0;
        n_data  = mk_meta(16'd0, 16'h0033);
        n_valid = 1'b1;
        @(negedge clk);
        r0 = n_ready;
        rv_seen = rv_seen | rp_valid;
        @(posedge clk);
        #1;
        n_data = mk_meta(16'd1600, 16'h0034);
        @(negedge clk);
        r1 = n_ready;
        rv_seen = rv_seen | rp_valid;
        @(posedge clk);
        #1;
        n_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rv_seen = rv_seen | rp_valid;
        end
        checks++; if (r0 !== 1'b1 || r1 !== 1'b1) begin
            failures++; $display("FAIL drop_b2b_ready got=%b%b exp=11", r0, r1); end
        checks++; if (drop_cnt !== 32'd2) begin failures++; $display("FAIL drop_b2b_cnt got=%0d exp=2", drop_cnt); end
        checks++; if (rv_seen !== 1'b0 || rp_q.size() !== 0) begin
            failures++; $display("FAIL drop_b2b_req got valid_seen=%b reqs=%0d exp 0/0", rv_seen, rp_q.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_b2b_busy got=%b exp=0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_len_limits();
        clear_q();
        send_notif(16'd1, 16'h0040);
        send_beat(mk_beat(16'h0400), 1'b1);
        wait_idle("len1");
        checks++; if (pk_q.size() !== 1) begin failures++; $display("FAIL len1_count got=%0d exp=1", pk_q.size()); end
        else begin
            checks++; if (pk_q[0] !== 64'h1 || pl_q[0] !== 1'b1) begin
                failures++; $display("FAIL len1_keep got=%h last=%b exp=1 last=1", pk_q[0], pl_q[0]); end
        end
        clear_q();
        send_notif(16'd1537, 16'h0041);
        repeat (3) @(negedge clk);
        checks++; if (drop_cnt !== 32'd3 || rp_q.size() !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL len1537_drop got drop=%0d reqs=%0d busy=%b exp 3/0/0", drop_cnt, rp_q.size(), busy); end
        @(posedge clk);
        #1;
        send_notif(16'd1536, 16'h0042);
        for (int b = 0; b < 24; b++) send_beat(mk_beat(16'(16'h0500 + b)), 1'(b == 23));
        wait_idle("len1536");
        checks++; if (rp_q.size() !== 1 || rp_q[0] !== {16'd1536, 16'h0042}) begin
            failures++; $display("FAIL len1536_req got reqs=%0d exp 1 request {1536,0042}", rp_q.size()); end
        checks++; if (pd_q.size() !== 24) begin failures++; $display("FAIL len1536_count got=%0d exp=24", pd_q.size()); end
        else begin
            checks++; if (pl_q[22] !== 1'b0 || pl_q[23] !== 1'b1 || pk_q[23] !== {BYTES{1'b1}}) begin
                failures++; $display("FAIL len1536_tail got last=%b%b keep=%h", pl_q[22], pl_q[23], pk_q[23]); end
            checks++; if (pd_q[23] !== {mk_meta(16'd1536, 16'h0042), mk_beat(16'h0517)}) begin
                failures++; $display("FAIL len1536_data got=%h", pd_q[23]); end
        end
        checks++; if (err_cnt !== 32'd0) begin failures++; $display("FAIL len1536_err got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_len_mismatch();
        logic bz;
        clear_q();
        send_notif(16'd192, 16'h0050);
        send_beat(mk_beat(16'h0600), 1'b0);
        send_beat(mk_beat(16'h0601), 1'b1);
        wait_idle("trunc");
        checks++; if (pd_q.size() !== 2) begin failures++; $display("FAIL trunc_count got=%0d exp=2", pd_q.size()); end
        else begin
            checks++; if (pl_q[0] !== 1'b0 || pl_q[1] !== 1'b1 || pk_q[1] !== {BYTES{1'b1}}) begin
                failures++; $display("FAIL trunc_tail got last=%b%b keep=%h", pl_q[0], pl_q[1], pk_q[1]); end
        end
        checks++; if (err_cnt !== 32'd1) begin failures++; $display("FAIL trunc_err got=%0d exp=1", err_cnt); end
        clear_q();
        send_notif(16'd64, 16'h0051);
        send_beat(mk_beat(16'h0700), 1'b0);
        bz = busy;
        send_beat(mk_beat(16'h0701), 1'b0);
        send_beat(mk_beat(16'h0702), 1'b1);
        wait_idle("flush");
        checks++; if (bz !== 1'b1) begin failures++; $display("FAIL flush_busy got=%b exp=1", bz); end
        checks++; if (pd_q.size() !== 1) begin failures++; $display("FAIL flush_count got=%0d exp=1", pd_q.size()); end
        else begin
            checks++; if (pd_q[0] !== {mk_meta(16'd64, 16'h0051), mk_beat(16'h0700)} || pl_q[0] !== 1'b1
                          || pk_q[0] !== {BYTES{1'b1}}) begin
                failures++; $display("FAIL flush_beat got last=%b keep=%h data=%h", pl_q[0], pk_q[0], pd_q[0]); end
        end
        checks++; if (err_cnt !== 32'd2 || drop_cnt !== 32'd3) begin
            failures++; $display("FAIL flush_counters got err=%0d drop=%0d exp 2/3", err_cnt, drop_cnt); end
    endtask

    task automatic test_random_stall();
        logic [PW-1:0]    e_d[$];
        logic [BYTES-1:0] e_k[$];
        logic             e_l[$];
        logic [63:0]      one;
        int               base_stall, mism, nb, rem, len;
        logic [DATA_W-1:0] beat;
        one = 64'd1;
        clear_q();
        base_stall = stall_err;
        rand_on = 1'b1;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 256);
            nb  = (len + 63) / 64;
            rem = len % 64;
            send_notif(16'(len), 16'(p));
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < DATA_W / 32; k++) beat[k*32 +: 32] = $urandom();
                e_d.push_back({mk_meta(16'(len), 16'(p)), beat});
                e_k.push_back((b == nb - 1 && rem != 0) ? BYTES'((one << rem) - 64'd1) : {BYTES{1'b1}});
                e_l.push_back(b == nb - 1);
                send_beat(beat, 1'(b == nb - 1));
            end
        end
        wait_idle("random");
        rand_on = 1'b0;
        @(posedge clk);
        #1;
        pkt_ready = 1'b1;
        mism = 0;
        for (int i = 0; i < pd_q.size() && i < e_d.size(); i++)
            if (pd_q[i] !== e_d[i] || pk_q[i] !== e_k[i] || pl_q[i] !== e_l[i]) mism++;
        checks++; if (pd_q.size() !== e_d.size()) begin
            failures++; $display("FAIL random_beat_count got=%0d exp=%0d", pd_q.size(), e_d.size()); end
        checks++; if (mism !== 0) begin failures++; $display("FAIL random_beat_content got=%0d bad beats exp=0", mism); end
        checks++; if (stall_err - base_stall !== 0) begin
            failures++; $display("FAIL random_stall_stable got=%0d changes exp=0", stall_err - base_stall); end
        checks++; if (rp_q.size() !== 100) begin failures++; $display("FAIL random_req_count got=%0d exp=100", rp_q.size()); end
        checks++; if (err_cnt !== 32'd2) begin failures++; $display("FAIL random_err got=%0d exp=2", err_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_q();
        send_notif(16'd320, 16'h0060);
        send_beat(mk_beat(16'h0800), 1'b0);
        send_beat(mk_beat(16'h0801), 1'b0);
        send_beat(mk_beat(16'h0802), 1'b0);
        checks++; if (pkt_valid !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL midrst_pre got valid=%b busy=%b exp 1/1", pkt_valid, busy); end
        rst = 1'b1;
        #1;
        checks++; if (pkt_valid !== 1'b0 || rp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midrst_valids got pkt=%b req=%b busy=%b exp 0/0/0", pkt_valid, rp_valid, busy); end
        checks++; if (drop_cnt !== 32'd0 || err_cnt !== 32'd0) begin
            failures++; $display("FAIL midrst_counters got=%0d/%0d exp=0/0", drop_cnt, err_cnt); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_q();
        send_notif(16'd64, 16'h0061);
        send_beat(mk_beat(16'h0900), 1'b1);
        wait_idle("postrst");
        checks++; if (rp_q.size() !== 1 || rp_q[0] !== {16'd64, 16'h0061}) begin
            failures++; $display("FAIL postrst_req got reqs=%0d exp 1 request {64,0061}", rp_q.size()); end
        checks++; if (pd_q.size() !== 1) begin failures++; $display("FAIL postrst_count got=%0d exp=1", pd_q.size()); end
        else begin
            checks++; if (pd_q[0] !== {mk_meta(16'd64, 16'h0061), mk_beat(16'h0900)} || pl_q[0] !== 1'b1
                          || pk_q[0] !== {BYTES{1'b1}}) begin
                failures++; $display("FAIL postrst_beat got last=%b keep=%h", pl_q[0], pk_q[0]); end
        end
        checks++; if (drop_cnt !== 32'd0 || err_cnt !== 32'd0) begin
            failures++; $display("FAIL postrst_counters got=%0d/%0d exp=0/0", drop_cnt, err_cnt); end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_partial_keep();
        test_drop_b2b();
        test_len_limits();
        test_len_mismatch();
        test_random_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
